// File: rtl/cic_decimator.sv
// cic_decimator: Hogenauer CIC decimator with run-time power-of-2 rate and gain-normalised output
module cic_decimator #(
    parameter int IN_WIDTH          = 16,
    parameter int STAGES            = 3,
    parameter int MAX_LOG2_RATE     = 4,
    parameter int DEFAULT_LOG2_RATE = 2,
    localparam int ACC_WIDTH        = IN_WIDTH + STAGES*MAX_LOG2_RATE,
    localparam int RW               = $clog2(MAX_LOG2_RATE+1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cfg_load,
    input  logic [RW-1:0]              log2_rate,
    input  logic                       in_valid,
    input  logic signed [IN_WIDTH-1:0] in_data,
    output logic                       out_valid,
    output logic signed [IN_WIDTH-1:0] out_data,
    output logic [RW-1:0]              rate_active
);
    localparam int SW = $clog2(STAGES*MAX_LOG2_RATE+1);

    logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
    logic signed [ACC_WIDTH-1:0] integ_d [STAGES];
    logic signed [ACC_WIDTH-1:0] dly_q   [STAGES];
    logic signed [ACC_WIDTH-1:0] dly_d   [STAGES];
    logic signed [ACC_WIDTH-1:0] sum     [STAGES];
    logic signed [ACC_WIDTH-1:0] comb    [STAGES];
    logic signed [ACC_WIDTH-1:0] dly_in  [STAGES];
    logic signed [ACC_WIDTH-1:0] x_ext;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [MAX_LOG2_RATE-1:0]    phase_q, phase_d, mask;
    logic [RW-1:0]               rate_q, rate_d, rate_req;
    logic [SW-1:0]               shift;
    logic signed [IN_WIDTH-1:0]  out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d, close;

    assign x_ext       = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign mask        = ~({MAX_LOG2_RATE{1'b1}} << rate_q);
    assign close       = in_valid && (phase_q == mask);
    assign shift       = SW'(STAGES) * SW'(rate_q);
    assign rate_req    = (log2_rate > RW'(MAX_LOG2_RATE)) ? RW'(MAX_LOG2_RATE) : log2_rate;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign rate_active = rate_q;

    // Integrator and comb chains plus next-state selection; cfg_load outranks an incoming sample
    always_comb begin
        sum[0] = integ_q[0] + x_ext;
        for (int k = 1; k < STAGES; k++) sum[k] = integ_q[k] + sum[k-1];
        comb[0]   = sum[STAGES-1] - dly_q[0];
        dly_in[0] = sum[STAGES-1];
        for (int k = 1; k < STAGES; k++) begin
            comb[k]   = comb[k-1] - dly_q[k];
            dly_in[k] = comb[k-1];
        end
        shifted     = comb[STAGES-1] >>> shift;
        integ_d     = integ_q;
        dly_d       = dly_q;
        phase_d     = phase_q;
        rate_d      = rate_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (cfg_load) begin
            rate_d  = rate_req;
            integ_d = '{default: '0};
            dly_d   = '{default: '0};
            phase_d = '0;
        end else if (in_valid) begin
            integ_d = sum;
            phase_d = close ? '0 : phase_q + MAX_LOG2_RATE'(1);
            if (close) begin
                dly_d       = dly_in;
                out_data_d  = shifted[IN_WIDTH-1:0];
                out_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial window
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            integ_q     <= '{default: '0};
            dly_q       <= '{default: '0};
            phase_q     <= '0;
            rate_q      <= RW'(DEFAULT_LOG2_RATE);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
